// File: rtl/apb_counter_regs.sv
// -----------------------------------------------------------------------------
// apb_counter_regs
//
// APB completer with a four-word register file that controls an 8-bit
// (CNT_W) free-running counter and a compare-match interrupt.
//
// Register map (byte offsets, word aligned, all other address bits zero):
//   0x0 CTRL  RW  [0] en, [1] irq_en, other bits read 0
//   0x4 COUNT RW  [CNT_W-1:0] counter value, a write loads the counter
//   0x8 CMP   RW  [CNT_W-1:0] compare value
//   0xC STAT  W1C [0] match (sticky)
//
// Ports:
//   pclk     in   APB clock, all logic on the rising edge
//   prst     in   synchronous active-high reset
//   paddr    in   byte address (ADDR_W bits)
//   pwdata   in   write data
//   prdata   out  read data, non-zero only during the ACCESS cycle of a read
//   psel     in   completer select
//   penable  in   access phase strobe
//   pwrite   in   1 = write, 0 = read
//   count_o  out  current counter value
//   irq      out  STAT.match & CTRL.irq_en
//   pslverr  out  error response (only when APB_PSLVERR_EN is defined)
//
// Optional feature macro: APB_PSLVERR_EN
//   When defined, the pslverr port exists and is raised during the ACCESS
//   cycle of unmapped transfers and of CTRL writes touching bits [31:2];
//   such writes are dropped. When undefined, unmapped accesses are silently
//   ignored and CTRL writes simply keep bits [1:0].
// -----------------------------------------------------------------------------
module apb_counter_regs #(
  parameter int CNT_W  = 8,
  parameter int ADDR_W = 32
) (
  input  logic              pclk,
  input  logic              prst,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [31:0]       pwdata,
  output logic [31:0]       prdata,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  output logic [CNT_W-1:0]  count_o,
  output logic              irq
`ifdef APB_PSLVERR_EN
  ,
  output logic              pslverr
`endif
);

  // State names describe the bus phase completed at the last edge:
  // ST_SETUP means a SETUP cycle was accepted, so the current cycle may be
  // the ACCESS cycle of that transfer.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_e;

  localparam logic [1:0] OFS_CTRL  = 2'd0;
  localparam logic [1:0] OFS_COUNT = 2'd1;
  localparam logic [1:0] OFS_CMP   = 2'd2;
  localparam logic [1:0] OFS_STAT  = 2'd3;

  state_e             state_q, state_d;

  logic               setup_s;
  logic               access_s;
  logic               addr_ok_s;
  logic               wr_ok_s;
  logic               wr_ctrl_s;
  logic               wr_count_s;
  logic               wr_cmp_s;
  logic               wr_stat_s;
  logic               match_s;
  logic [31:0]        rdata_s;

  logic               en_q, en_d;
  logic               irq_en_q, irq_en_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [CNT_W-1:0]   cmp_q, cmp_d;
  logic               stat_q, stat_d;
  logic [31:0]        prdata_q, prdata_d;

`ifdef APB_PSLVERR_EN
  logic               ctrl_rsvd_s;
  logic               err_q, err_d;
`endif

  // pwdata bits above the stored fields are intentionally discarded.
  logic               unused_pwdata_s;
  assign unused_pwdata_s = ^pwdata;

  assign setup_s  = psel & ~penable;
  // An ACCESS cycle only counts when it directly follows an accepted SETUP;
  // a bare psel+penable from IDLE is a protocol violation and is ignored.
  assign access_s = (state_q == ST_SETUP) & psel & penable;

  // Only bits [3:2] may be non-zero in a mapped address.
  assign addr_ok_s = ((paddr & ~ADDR_W'(32'hC)) == '0);

`ifdef APB_PSLVERR_EN
  assign ctrl_rsvd_s = (paddr[3:2] == OFS_CTRL) & pwrite & (|pwdata[31:2]);
  assign wr_ok_s     = access_s & pwrite & addr_ok_s & ~ctrl_rsvd_s;
`else
  assign wr_ok_s     = access_s & pwrite & addr_ok_s;
`endif

  assign wr_ctrl_s  = wr_ok_s & (paddr[3:2] == OFS_CTRL);
  assign wr_count_s = wr_ok_s & (paddr[3:2] == OFS_COUNT);
  assign wr_cmp_s   = wr_ok_s & (paddr[3:2] == OFS_CMP);
  assign wr_stat_s  = wr_ok_s & (paddr[3:2] == OFS_STAT);

  // Match looks at the registered counter, so STAT (and irq) rises one
  // cycle after the counter value reaches CMP.
  assign match_s = (count_q == cmp_q);

  // Bus phase tracking: next-state decode.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (setup_s) begin
          state_d = ST_SETUP;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SETUP: begin
        if (psel && penable) begin
          state_d = ST_ACCESS;
        end else if (setup_s) begin
          state_d = ST_SETUP;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        if (setup_s) begin
          state_d = ST_SETUP;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Control register next-state.
  always_comb begin
    en_d     = en_q;
    irq_en_d = irq_en_q;
    if (wr_ctrl_s) begin
      en_d     = pwdata[0];
      irq_en_d = pwdata[1];
    end else begin
      en_d     = en_q;
      irq_en_d = irq_en_q;
    end
  end

  // Counter next-state: a bus load overrides the increment in that cycle.
  always_comb begin
    count_d = count_q;
    if (wr_count_s) begin
      count_d = pwdata[CNT_W-1:0];
    end else if (en_q) begin
      count_d = count_q + CNT_W'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Compare register next-state.
  always_comb begin
    cmp_d = cmp_q;
    if (wr_cmp_s) begin
      cmp_d = pwdata[CNT_W-1:0];
    end else begin
      cmp_d = cmp_q;
    end
  end

  // Sticky match flag: a new match beats a simultaneous write-1-to-clear.
  always_comb begin
    stat_d = stat_q;
    if (match_s) begin
      stat_d = 1'b1;
    end else if (wr_stat_s && pwdata[0]) begin
      stat_d = 1'b0;
    end else begin
      stat_d = stat_q;
    end
  end

  // Read multiplexer over the register file.
  always_comb begin
    rdata_s = 32'h0000_0000;
    case (paddr[3:2])
      OFS_CTRL: begin
        rdata_s[0] = en_q;
        rdata_s[1] = irq_en_q;
      end
      OFS_COUNT: begin
        rdata_s[CNT_W-1:0] = count_q;
      end
      OFS_CMP: begin
        rdata_s[CNT_W-1:0] = cmp_q;
      end
      OFS_STAT: begin
        rdata_s[0] = stat_q;
      end
      default: begin
        rdata_s = 32'h0000_0000;
      end
    endcase
  end

  // Read data is captured at the end of the SETUP cycle; writes and
  // unmapped reads return zero.
  always_comb begin
    prdata_d = 32'h0000_0000;
    if ((state_d == ST_SETUP) && !pwrite && addr_ok_s) begin
      prdata_d = rdata_s;
    end else begin
      prdata_d = 32'h0000_0000;
    end
  end

`ifdef APB_PSLVERR_EN
  // Error response is decided at the end of the SETUP cycle as well.
  always_comb begin
    err_d = 1'b0;
    if (state_d == ST_SETUP) begin
      err_d = ~addr_ok_s | ctrl_rsvd_s;
    end else begin
      err_d = 1'b0;
    end
  end
`endif

  // State and register file flops with synchronous reset.
  always_ff @(posedge pclk) begin
    if (prst) begin
      state_q  <= ST_IDLE;
      en_q     <= 1'b0;
      irq_en_q <= 1'b0;
      count_q  <= '0;
      cmp_q    <= '1;
      stat_q   <= 1'b0;
      prdata_q <= 32'h0000_0000;
    end else begin
      state_q  <= state_d;
      en_q     <= en_d;
      irq_en_q <= irq_en_d;
      count_q  <= count_d;
      cmp_q    <= cmp_d;
      stat_q   <= stat_d;
      prdata_q <= prdata_d;
    end
  end

`ifdef APB_PSLVERR_EN
  // Error response flop.
  always_ff @(posedge pclk) begin
    if (prst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign pslverr = access_s & err_q;
`endif

  // The captured read data is only presented while the ACCESS cycle is on
  // the bus, so an aborted SETUP never shows stale data.
  assign prdata  = access_s ? prdata_q : 32'h0000_0000;
  assign count_o = count_q;
  assign irq     = stat_q & irq_en_q;

endmodule

// File: tb/tb_apb_counter_regs.sv
// -----------------------------------------------------------------------------
// tb_apb_counter_regs
//
// Randomised plus directed stimulus against a cycle-level reference model of
// the register file. Expected read responses are queued when a transfer's
// SETUP phase is driven; a monitor pops and compares them on every ACCESS
// phase seen on the bus, and checks count_o / irq every cycle.
// -----------------------------------------------------------------------------
module tb_apb_counter_regs;

  localparam int          CNT_W = 8;
  localparam logic [31:0] MASK  = 32'h0000_00FF;

  typedef struct packed {
    logic [31:0] rd;
    logic        err;
  } exp_t;

  logic              pclk;
  logic              prst;
  logic [31:0]       paddr;
  logic [31:0]       pwdata;
  logic [31:0]       prdata;
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [CNT_W-1:0]  count_o;
  logic              irq;
`ifdef APB_PSLVERR_EN
  logic              pslverr;
`endif

  apb_counter_regs #(.CNT_W(CNT_W), .ADDR_W(32)) dut (
    .pclk    (pclk),
    .prst    (prst),
    .paddr   (paddr),
    .pwdata  (pwdata),
    .prdata  (prdata),
    .psel    (psel),
    .penable (penable),
    .pwrite  (pwrite),
    .count_o (count_o),
    .irq     (irq)
`ifdef APB_PSLVERR_EN
    ,
    .pslverr (pslverr)
`endif
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  int          total = 0;
  int          bad   = 0;
  logic        chk_en = 1'b0;
  exp_t        sb_q[$];
  exp_t        e_mon;

  // Reference model state: the register contents as the spec defines them.
  logic [31:0] m_ctrl;
  logic [31:0] m_cnt;
  logic [31:0] m_cmp;
  logic        m_stat;

  // Committed-write strobe, raised by the stimulus during a legal ACCESS.
  logic        cm_wr   = 1'b0;
  logic [31:0] cm_addr = 32'h0;
  logic [31:0] cm_data = 32'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic is_mapped(input logic [31:0] a);
    return ((a & ~32'hC) == 32'h0);
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    if (!is_mapped(a)) return 32'h0;
    case (a[3:2])
      2'd0:    return m_ctrl & 32'h3;
      2'd1:    return m_cnt;
      2'd2:    return m_cmp;
      default: return {31'h0, m_stat};
    endcase
  endfunction

  // Reference model: one update per clock edge.
  always @(posedge pclk) begin : ref_model
    logic [31:0] nxt_cnt;
    logic        hit;
    logic        clr;
    if (prst) begin
      m_ctrl <= 32'h0;
      m_cnt  <= 32'h0;
      m_cmp  <= MASK;
      m_stat <= 1'b0;
    end else begin
      hit     = (m_cnt == m_cmp);
      nxt_cnt = m_ctrl[0] ? ((m_cnt + 32'd1) & MASK) : m_cnt;
      clr     = 1'b0;
      if (cm_wr) begin
        case (cm_addr[3:2])
          2'd0:    m_ctrl <= cm_data & 32'h3;
          2'd1:    nxt_cnt = cm_data & MASK;
          2'd2:    m_cmp <= cm_data & MASK;
          default: clr = cm_data[0];
        endcase
      end
      m_cnt  <= nxt_cnt;
      m_stat <= hit ? 1'b1 : (clr ? 1'b0 : m_stat);
    end
  end

  // Monitor: compares outputs on the falling edge.
  always @(negedge pclk) begin
    if (chk_en) begin
      check("count_o", {24'h0, count_o}, m_cnt);
      check("irq", {31'h0, irq}, {31'h0, m_stat & m_ctrl[1]});
      if (psel && penable) begin
        if (sb_q.size() == 0) begin
          check("sb_nonempty", sb_q.size(), 1);
        end else begin
          e_mon = sb_q.pop_front();
          check("prdata", prdata, e_mon.rd);
`ifdef APB_PSLVERR_EN
          check("pslverr", {31'h0, pslverr}, {31'h0, e_mon.err});
`endif
        end
      end else begin
        check("prdata_idle", prdata, 32'h0);
`ifdef APB_PSLVERR_EN
        check("pslverr_idle", {31'h0, pslverr}, 32'h0);
`endif
      end
    end
  end

  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  task automatic bus_idle();
    psel    = 1'b0;
    penable = 1'b0;
    pwrite  = 1'b0;
  endtask

  task automatic idle(input int n);
    bus_idle();
    repeat (n) step();
  endtask

  // One complete transfer (SETUP + ACCESS); returns with the bus idle and
  // the time 1 unit after the edge that closed the ACCESS cycle.
  task automatic apb_xfer(input logic wr, input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    logic mapped;
    logic rsvd;
    mapped = is_mapped(a);
    rsvd   = wr && (a[3:2] == 2'd0) && (d[31:2] != 30'h0);
    psel    = 1'b1;
    penable = 1'b0;
    pwrite  = wr;
    paddr   = a;
    pwdata  = d;
    e.rd    = wr ? 32'h0 : model_read(a);
`ifdef APB_PSLVERR_EN
    e.err   = !mapped || rsvd;
`else
    e.err   = 1'b0;
`endif
    sb_q.push_back(e);
    step();
    penable = 1'b1;
    cm_addr = a;
    cm_data = d;
`ifdef APB_PSLVERR_EN
    cm_wr   = wr && mapped && !rsvd;
`else
    cm_wr   = wr && mapped;
`endif
    step();
    cm_wr = 1'b0;
    bus_idle();
  endtask

  initial begin
    exp_t ev;
    prst    = 1'b1;
    paddr   = 32'h0;
    pwdata  = 32'h0;
    bus_idle();
    repeat (3) step();
    chk_en = 1'b1;
    prst   = 1'b0;

    // Reset values of all four registers.
    apb_xfer(1'b0, 32'h0, 32'h0);
    apb_xfer(1'b0, 32'h4, 32'h0);
    apb_xfer(1'b0, 32'h8, 32'h0);
    apb_xfer(1'b0, 32'hC, 32'h0);
    idle(2);

    // Count up to a compare value, clear the interrupt, run through wrap.
    apb_xfer(1'b1, 32'h8, 32'h0000_0005);
    apb_xfer(1'b1, 32'h0, 32'h0000_0003);
    idle(10);
    apb_xfer(1'b0, 32'hC, 32'h0);
    apb_xfer(1'b1, 32'hC, 32'h0000_0001);
    idle(270);

    // Load while counting: load wins, then counting resumes.
    apb_xfer(1'b1, 32'h4, 32'hFFFF_FF80);
    idle(3);
    apb_xfer(1'b0, 32'h4, 32'h0);

    // Clear collides with a persistent match: set wins.
    apb_xfer(1'b1, 32'h0, 32'h0000_0002);
    apb_xfer(1'b1, 32'h4, 32'h0000_0020);
    apb_xfer(1'b1, 32'h8, 32'h0000_0020);
    idle(2);
    apb_xfer(1'b1, 32'hC, 32'h0000_0001);
    apb_xfer(1'b0, 32'hC, 32'h0);
    apb_xfer(1'b1, 32'h8, 32'h0000_0021);
    apb_xfer(1'b1, 32'hC, 32'h0000_0001);
    apb_xfer(1'b0, 32'hC, 32'h0);

    // ACCESS without SETUP is ignored.
    idle(1);
    psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 32'h8; pwdata = 32'h42;
    ev.rd = 32'h0; ev.err = 1'b0;
    sb_q.push_back(ev);
    step();
    idle(1);
    // psel dropped after SETUP: aborted, no side effects.
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h8; pwdata = 32'h77;
    step();
    idle(1);
    apb_xfer(1'b0, 32'h8, 32'h0);

    // Unmapped addresses.
    apb_xfer(1'b1, 32'h10, 32'h0000_00AB);
    apb_xfer(1'b0, 32'h10, 32'h0);
    apb_xfer(1'b0, 32'h6, 32'h0);
    apb_xfer(1'b1, 32'h8000_0008, 32'h12);
    apb_xfer(1'b0, 32'h8, 32'h0);

    // Reset in the middle of a transfer, then an immediate fresh SETUP.
    apb_xfer(1'b1, 32'h0, 32'h0000_0001);
    idle(4);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h8; pwdata = 32'h33;
    prst = 1'b1;
    step();
    prst = 1'b0;
    apb_xfer(1'b0, 32'h8, 32'h0);
    apb_xfer(1'b0, 32'h4, 32'h0);

    // Randomised traffic with random gaps (including back-to-back).
    for (int i = 0; i < 300; i++) begin
      int unsigned r;
      logic [31:0] a;
      logic [31:0] d;
      logic        wr;
      r = $urandom_range(0, 11);
      if (r < 8) begin
        a = 32'(r % 4) << 2;
      end else if (r < 10) begin
        a = (32'h1 << $urandom_range(4, 31)) | (32'($urandom_range(0, 3)) << 2);
      end else begin
        a = (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(1, 3));
      end
      wr = 1'($urandom_range(0, 1));
      d  = $urandom;
      if ((a[3:2] == 2'd0) && ($urandom_range(0, 3) != 0)) d = 32'($urandom_range(0, 3));
      if ((a[3:2] == 2'd2) && ($urandom_range(0, 1) != 0)) d = (m_cnt + 32'($urandom_range(1, 6))) & MASK;
      apb_xfer(wr, a, d);
      idle($urandom_range(0, 2));
    end

    idle(3);
    check("sb_empty", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
